// File: rtl/mode_scheduler.sv
// Avalon-MM slave arbitrating the greenhouse MANUAL/AUTO mode line between software
// requests and a priority hardware fault, with switch dwell and a latched SAFE state.
module mode_scheduler #(
  parameter int DWELL_W     = 24,
  parameter int DWELL_RESET = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        fault_req,
  output logic        mode_out,
  output logic        safe_active,
  output logic        irq
);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_SAFE   = 2'd2;

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_DWELL   = 2'd1;
  localparam logic [1:0] A_STATUS  = 2'd2;
  localparam logic [1:0] A_SWCOUNT = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic               mode_reg, mode_next;
  logic               req_mode_reg, req_mode_next;
  logic               pending_reg, pending_next;
  logic               irq_reg, irq_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic [CNT_W-1:0]   swcount_reg, swcount_next;

  logic wr_en;
  logic ctrl_wr;
  logic safe_ack;
  logic mode_change;

  assign wr_en    = chipselect & ~write_n;
  assign ctrl_wr  = wr_en && (address == A_CTRL);
  assign safe_ack = ctrl_wr && writedata[1];

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    req_mode_next = req_mode_reg;
    pending_next  = pending_reg;
    irq_next      = irq_reg;
    case (state_reg)
      ST_MANUAL, ST_AUTO: begin
        if (fault_req) begin
          state_next = ST_SAFE;
          mode_next  = 1'b0;
          irq_next   = 1'b1;
        end else if (pending_reg && (dwell_cnt_reg == '0)) begin
          pending_next = 1'b0;
          if (req_mode_reg != mode_reg) begin
            state_next = req_mode_reg ? ST_AUTO : ST_MANUAL;
            mode_next  = req_mode_reg;
          end
        end
      end
      ST_SAFE: begin
        mode_next = 1'b0;
        if (safe_ack && !fault_req) begin
          state_next = ST_MANUAL;
          irq_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_MANUAL;
        mode_next  = 1'b0;
      end
    endcase
    // A CTRL write lands after the decision, so it re-arms pending even on a switch edge.
    if (ctrl_wr) begin
      req_mode_next = writedata[0];
      pending_next  = 1'b1;
    end
  end

  assign mode_change = (mode_next != mode_reg);

  always_comb begin
    dwell_next = dwell_reg;
    if (wr_en && (address == A_DWELL)) begin
      dwell_next = writedata[DWELL_W-1:0];
    end
    dwell_cnt_next = dwell_cnt_reg;
    if (mode_change) begin
      dwell_cnt_next = dwell_reg;
    end else if (dwell_cnt_reg != '0) begin
      dwell_cnt_next = dwell_cnt_reg - DWELL_W'(1);
    end
    swcount_next = swcount_reg;
    if (wr_en && (address == A_SWCOUNT)) begin
      swcount_next = '0;
    end else if (mode_change && !(&swcount_reg)) begin
      swcount_next = swcount_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_MANUAL;
      mode_reg      <= 1'b0;
      req_mode_reg  <= 1'b0;
      pending_reg   <= 1'b0;
      irq_reg       <= 1'b0;
      dwell_reg     <= DWELL_W'(DWELL_RESET);
      dwell_cnt_reg <= '0;
      swcount_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      req_mode_reg  <= req_mode_next;
      pending_reg   <= pending_next;
      irq_reg       <= irq_next;
      dwell_reg     <= dwell_next;
      dwell_cnt_reg <= dwell_cnt_next;
      swcount_reg   <= swcount_next;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:    readdata = {31'b0, req_mode_reg};
      A_DWELL:   readdata = 32'(dwell_reg);
      A_STATUS:  readdata = {26'b0, irq_reg, pending_reg, (dwell_cnt_reg != '0),
                            (state_reg == ST_SAFE), state_reg};
      A_SWCOUNT: readdata = 32'(swcount_reg);
      default:   readdata = '0;
    endcase
  end

  assign mode_out    = mode_reg;
  assign safe_active = (state_reg == ST_SAFE);
  assign irq         = irq_reg;

endmodule

// File: tb/tb_mode_scheduler.sv
// Scoreboard bench for mode_scheduler: a cycle model queues expected outputs per
// driven cycle; they are popped and compared one cycle later. Reads compare live.
module tb_mode_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata4;
  logic        fault_req;
  logic        mode_out, safe_active, irq;
  logic        mode_out4, safe_active4, irq4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_scheduler dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .fault_req(fault_req), .mode_out(mode_out), .safe_active(safe_active), .irq(irq)
  );

  mode_scheduler #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4),
    .fault_req(fault_req), .mode_out(mode_out4), .safe_active(safe_active4), .irq(irq4)
  );

  // model state
  logic [1:0]  m_state;
  logic        m_mode, m_req, m_pend, m_irq;
  logic [23:0] m_dreg, m_dcnt;
  logic [15:0] m_sw16;
  logic [3:0]  m_sw4;
  logic        fault_lvl;
  logic [31:0] last_rd, last_rd4;
  logic [2:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a, input logic [15:0] sw);
    case (a)
      2'd0:    return {31'b0, m_req};
      2'd1:    return {8'b0, m_dreg};
      2'd2:    return {26'b0, m_irq, m_pend, (m_dcnt != 0), (m_state == 2'd2), m_state};
      default: return {16'b0, sw};
    endcase
  endfunction

  // One clock cycle: drive, compare reads, advance the model, queue and score outputs.
  task automatic tick(input logic rst, input logic cs, input logic wn,
                      input logic [1:0] a, input logic [31:0] d);
    logic [1:0]  n_state;
    logic        n_mode, n_req, n_pend, n_irq, wr, cw;
    logic [23:0] n_dreg, n_dcnt;
    logic [15:0] n_sw16;
    logic [3:0]  n_sw4;
    logic [2:0]  exp;
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
    fault_req = fault_lvl;
    #1;
    last_rd = readdata; last_rd4 = readdata4;
    if (cs && wn && !rst) begin
      check($sformatf("rd%0d", a), readdata, model_rd(a, m_sw16));
      check($sformatf("rd4_%0d", a), readdata4, model_rd(a, {12'b0, m_sw4}));
    end
    wr = cs && !wn;
    cw = wr && (a == 2'd0);
    n_state = m_state; n_mode = m_mode; n_req = m_req; n_pend = m_pend; n_irq = m_irq;
    n_dreg = m_dreg; n_dcnt = m_dcnt; n_sw16 = m_sw16; n_sw4 = m_sw4;
    if (m_state == 2'd2) begin
      if (cw && d[1] && !fault_lvl) begin n_state = 2'd0; n_irq = 1'b0; end
    end else if (fault_lvl) begin
      n_state = 2'd2; n_mode = 1'b0; n_irq = 1'b1;
    end else if (m_pend && m_dcnt == 0) begin
      n_pend = 1'b0;
      if (m_req != m_mode) begin n_mode = m_req; n_state = {1'b0, m_req}; end
    end
    if (cw) begin n_req = d[0]; n_pend = 1'b1; end
    if (wr && a == 2'd1) n_dreg = d[23:0];
    if (n_mode != m_mode) n_dcnt = m_dreg;
    else if (m_dcnt != 0) n_dcnt = m_dcnt - 1;
    if (wr && a == 2'd3) begin
      n_sw16 = 0; n_sw4 = 0;
    end else if (n_mode != m_mode) begin
      if (m_sw16 != 16'hffff) n_sw16 = m_sw16 + 1;
      if (m_sw4 != 4'hf) n_sw4 = m_sw4 + 1;
    end
    if (rst) begin
      n_state = 0; n_mode = 0; n_req = 0; n_pend = 0; n_irq = 0;
      n_dreg = 24'd50000; n_dcnt = 0; n_sw16 = 0; n_sw4 = 0;
    end
    exp_q.push_back({n_mode, (n_state == 2'd2), n_irq});
    @(posedge clk); #1;
    m_state = n_state; m_mode = n_mode; m_req = n_req; m_pend = n_pend; m_irq = n_irq;
    m_dreg = n_dreg; m_dcnt = n_dcnt; m_sw16 = n_sw16; m_sw4 = n_sw4;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check("outs", {29'b0, mode_out, safe_active, irq}, {29'b0, exp});
      check("outs4", {29'b0, mode_out4, safe_active4, irq4}, {29'b0, exp});
      $display("t=%0t cs=%0b wn=%0b a=%0d d=0x%0h f=%0b -> mode=%0b safe=%0b irq=%0b",
               $time, cs, wn, a, d, fault_lvl, mode_out, safe_active, irq);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d); tick(0, 1, 0, a, d); endtask
  task automatic rd_reg(input logic [1:0] a); tick(0, 1, 1, a, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) tick(0, 0, 1, 0, 0); endtask
  task automatic do_reset(); tick(1, 0, 1, 0, 0); endtask

  initial begin
    fault_lvl = 0;
    m_state = 0; m_mode = 0; m_req = 0; m_pend = 0; m_irq = 0;
    m_dreg = 24'd50000; m_dcnt = 0; m_sw16 = 0; m_sw4 = 0;
    @(posedge clk); #1;
    do_reset();
    // T1: reset values
    rd_reg(0); check("t1_ctrl", last_rd, 32'd0);
    rd_reg(1); check("t1_dwell", last_rd, 32'd50000);
    rd_reg(2); check("t1_status", last_rd, 32'd0);
    rd_reg(3); check("t1_swcount", last_rd, 32'd0);
    check("t1_mode", {31'b0, mode_out}, 32'd0);

    // T2: dwell-limited back-to-back switches
    wr_reg(1, 10);
    wr_reg(0, 1);
    check("t2_mode_after_wr", {31'b0, mode_out}, 32'd0);
    idle(1);
    check("t2_first_switch", {31'b0, mode_out}, 32'd1);
    idle(1);
    wr_reg(0, 0);
    for (int i = 0; i < 14; i++) begin
      rd_reg(2);
    end
    rd_reg(3); check("t2_swcount", last_rd, 32'd2);

    // T3: AUTO with blocked pending, then fault
    wr_reg(1, 20);
    wr_reg(0, 1);
    idle(25);
    wr_reg(0, 0);
    idle(2);
    rd_reg(2);
    fault_lvl = 1;
    idle(1);
    check("t3_safe", {31'b0, safe_active}, 32'd1);
    rd_reg(2);

    // T4: ack ignored under fault, then accepted
    wr_reg(0, 2);
    rd_reg(2);
    fault_lvl = 0;
    idle(2);
    wr_reg(0, 2);
    check("t4_manual", {31'b0, safe_active}, 32'd0);
    rd_reg(2);
    idle(25);

    // T5: request made inside SAFE takes effect after exit
    fault_lvl = 1; idle(1); fault_lvl = 0;
    wr_reg(0, 1);
    wr_reg(0, 3);
    for (int i = 0; i < 25; i++) rd_reg(2);
    check("t5_auto", {31'b0, mode_out}, 32'd1);

    // T6: saturation of the 4-bit counter, then clear
    wr_reg(1, 0);
    idle(22);
    wr_reg(3, 0);
    for (int i = 0; i < 20; i++) begin
      wr_reg(0, (i % 2 == 0) ? 32'd0 : 32'd1);
      idle(1);
    end
    rd_reg(3);
    check("t6_sat4", last_rd4, 32'd15);
    wr_reg(3, 0);
    rd_reg(3); check("t6_clear", last_rd4, 32'd0);

    // clear wins over a simultaneous switch
    wr_reg(0, {31'b0, ~mode_out});
    wr_reg(3, 0);
    rd_reg(3); check("clr_vs_switch", last_rd, 32'd0);

    // reset mid-SAFE
    fault_lvl = 1; idle(2); fault_lvl = 0;
    do_reset();
    rd_reg(2); check("rst_safe_status", last_rd, 32'd0);
    rd_reg(1); check("rst_safe_dwell", last_rd, 32'd50000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
